// File: rtl/alu8_arbiter.sv
// Two-requester front end for a shared combinational 8-bit ALU: round-robin grant,
// registered ALU operands held for EXEC_CYCLES, result returned on one tagged response channel.

module alu8_arbiter #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_result,
  output logic             rsp_err,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_r;
  logic       last_grant_r;
  logic [3:0] settle_r;
  logic       grant_s;
  logic       accept_s;

  // Error flag: divide by zero or any opcode outside the supported add/sub/mul/div set.
  function automatic logic calc_err(input logic [2:0] op, input logic [7:0] b);
    return ((op == 3'b011) && (b == 8'd0)) || op[2];
  endfunction

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_s = last_grant_r;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req0_valid) begin
      grant_s = 1'b0;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = last_grant_r;
    end
  end

  assign req0_ready = (state_r == IDLE) && req0_valid && (grant_s == 1'b0);
  assign req1_ready = (state_r == IDLE) && req1_valid && (grant_s == 1'b1);
  assign accept_s   = req0_ready || req1_ready;

  // Control FSM with all response/ALU-side outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      settle_r     <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 8'd0;
      rsp_err      <= 1'b0;
      alu_a        <= 8'd0;
      alu_b        <= 8'd0;
      alu_opcode   <= 3'd0;
      busy         <= 1'b0;
      op_count     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_a        <= grant_s ? req1_a  : req0_a;
            alu_b        <= grant_s ? req1_b  : req0_b;
            alu_opcode   <= grant_s ? req1_op : req0_op;
            rsp_id       <= grant_s;
            last_grant_r <= grant_s;
            settle_r     <= SETTLE_LOAD;
            busy         <= 1'b1;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          if (settle_r != 4'd0) begin
            settle_r <= settle_r - 4'd1;
          end else begin
            rsp_result <= alu_result;
            rsp_err    <= calc_err(alu_opcode, alu_b);
            rsp_valid  <= 1'b1;
            state_r    <= RESP;
          end
        end
        RESP: begin
          // Hold the response until the consumer takes it; nothing is dropped.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            op_count  <= op_count + CNT_ONE;
            state_r   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu8_arbiter.sv
// Scoreboard bench for alu8_arbiter: main instance (EXEC_CYCLES=1, CNT_W=4) plus a
// second instance (EXEC_CYCLES=4) for settle-time and latency checks.

module tb_alu8_arbiter;

  localparam int EXEC_A = 1;
  localparam int CNT_A  = 4;
  localparam int EXEC_B = 4;

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic             req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  logic             req0_ready, req1_ready;
  logic [7:0]       req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic [2:0]       req0_op = 3'd0, req1_op = 3'd0;
  logic             rsp_valid, rsp_id, rsp_err, busy;
  logic [7:0]       rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]       alu_opcode;
  logic [CNT_A-1:0] op_count;

  logic        b_req0_valid = 1'b0, b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_rsp_err, b_busy;
  logic [7:0]  b_req0_a = 8'd0, b_req0_b = 8'd0, b_rsp_result, b_alu_a, b_alu_b, b_alu_result;
  logic [2:0]  b_req0_op = 3'd0, b_alu_opcode;
  logic [15:0] b_op_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  logic grant_hist[$];
  logic exp_last = 1'b1;
  logic [CNT_A-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a * b;
      3'b011:  return (b == 8'd0) ? 8'hFF : a / b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result   = alu_model(alu_a, alu_b, alu_opcode);
  assign b_alu_result = alu_model(b_alu_a, b_alu_b, b_alu_opcode);

  alu8_arbiter #(.EXEC_CYCLES(EXEC_A), .CNT_W(CNT_A)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .busy(busy), .op_count(op_count)
  );

  alu8_arbiter #(.EXEC_CYCLES(EXEC_B), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_op(b_req0_op),
    .req1_valid(1'b0), .req1_ready(b_req1_ready), .req1_a(8'd0), .req1_b(8'd0), .req1_op(3'd0),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_id(b_rsp_id), .rsp_result(b_rsp_result), .rsp_err(b_rsp_err),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_opcode(b_alu_opcode), .alu_result(b_alu_result),
    .busy(b_busy), .op_count(b_op_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: grant model and scoreboard push on acceptance, pop and compare on response.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt  = '0;
      exp_last = 1'b1;
    end else begin
      if (req0_ready || req1_ready) begin
        logic g;
        exp_t e;
        g = (req0_valid && req1_valid) ? ~exp_last : req1_valid;
        check_eq("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        check_eq("grant", {31'd0, req1_ready}, {31'd0, g});
        e.id  = g;
        e.res = g ? alu_model(req1_a, req1_b, req1_op) : alu_model(req0_a, req0_b, req0_op);
        e.err = g ? (((req1_op == 3'b011) && (req1_b == 8'd0)) || req1_op[2])
                  : (((req0_op == 3'b011) && (req0_b == 8'd0)) || req0_op[2]);
        sb_q.push_back(e);
        grant_hist.push_back(req1_ready);
        exp_last = g;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          check_eq("rsp_result", {24'd0, rsp_result}, {24'd0, e.res});
          check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check_eq("op_count", {28'd0, op_count}, {28'd0, exp_cnt});
          exp_cnt = exp_cnt + 4'd1;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, output int waited);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    waited = 0;
    forever begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) break;
      waited++;
      if (waited > 100) begin
        check_eq("issue_timeout", waited, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Counts edges from the acceptance edge (inclusive) to the edge that raises rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      lat++;
      if (lat > 100) begin
        check_eq("rsp_timeout", lat, 32'd0);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) return;
    end
    check_eq("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int w, lat, stab;
    int base;
    do_reset();

    @(negedge clk);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_alu", {13'd0, alu_a, alu_b, alu_opcode}, 32'd0);
    check_eq("rst_rsp", {22'd0, rsp_id, rsp_result, rsp_err}, 32'd0);
    check_eq("rst_op_count", {28'd0, op_count}, 32'd0);

    // Basic add with latency and counter.
    @(posedge clk); #1;
    issue(1'b0, 8'd20, 8'd22, 3'b000, w);
    check_eq("ready_first_cycle", w, 32'd0);
    wait_rsp(lat);
    check_eq("latency_e1", lat, EXEC_A + 1);
    check_eq("rsp_val_42", {24'd0, rsp_result}, 32'd42);
    @(negedge clk);
    check_eq("op_count_1", {28'd0, op_count}, 32'd1);

    // Both requesters continuously valid: grants must alternate starting with 0.
    do_reset();
    grant_hist.delete();
    req0_a = 8'd10; req0_b = 8'd3; req0_op = 3'b001;
    req1_a = 8'd6;  req1_b = 8'd7; req1_op = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 200 && grant_hist.size() < 4; i++) @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("rr_count", grant_hist.size(), 32'd4);
    for (int i = 0; i < grant_hist.size(); i++)
      check_eq("rr_seq", {31'd0, grant_hist[i]}, i % 2);
    wait_idle();

    // Divide by zero and unsupported opcode.
    @(posedge clk); #1;
    issue(1'b1, 8'd9, 8'd0, 3'b011, w);
    issue(1'b1, 8'd9, 8'd0, 3'b100, w);
    wait_idle();

    // Backpressure: response held, new request blocked until consumer accepts.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1'b0, 8'd100, 8'd27, 3'b001, w);
    wait_rsp(lat);
    req0_a = 8'd5; req0_b = 8'd5; req0_op = 3'b000; req0_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_rsp", {21'd0, rsp_valid, rsp_id, rsp_result, rsp_err}, {21'd0, 1'b1, 1'b0, 8'd73, 1'b0});
      check_eq("bp_ready0", {31'd0, req0_ready}, 32'd0);
      check_eq("bp_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("accept_after_release", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_idle();

    // Reset while in EXEC discards the transaction.
    @(posedge clk); #1;
    issue(1'b0, 8'd1, 8'd2, 3'b000, w);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_outs", {10'd0, rsp_valid, busy, alu_a, alu_b, alu_opcode, rsp_err}, 32'd0);
    check_eq("mid_rst_rsp", {23'd0, rsp_id, rsp_result}, 32'd0);
    check_eq("mid_rst_cnt", {28'd0, op_count}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      check_eq("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
    end

    // Sixteen completions wrap a 4-bit counter back to zero.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++)
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            3'($urandom_range(0, 7)), w);
    wait_idle();
    check_eq("op_count_wrap", {28'd0, op_count}, 32'd0);
    check_eq("sb_drain", sb_q.size(), 32'd0);

    // Second instance: operands stable for EXEC_B cycles, response after EXEC_B+1 edges.
    @(posedge clk); #1;
    b_req0_a = 8'd200; b_req0_b = 8'd100; b_req0_op = 3'b000; b_req0_valid = 1'b1;
    base = 0;
    while (base < 50) begin
      @(negedge clk);
      if (b_req0_ready) break;
      base++;
    end
    check_eq("b_accept", {31'd0, b_req0_ready}, 32'd1);
    @(posedge clk); #1 b_req0_valid = 1'b0;
    lat = 1;
    stab = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (b_rsp_valid) break;
      check_eq("b_alu_stable", {13'd0, b_alu_a, b_alu_b, b_alu_opcode}, {13'd0, 8'd200, 8'd100, 3'b000});
      stab++;
      lat++;
    end
    check_eq("b_latency", lat, EXEC_B + 1);
    check_eq("b_stable_cycles", stab, EXEC_B);
    check_eq("b_rsp", {22'd0, b_rsp_id, b_rsp_result, b_rsp_err}, {22'd0, 1'b0, 8'd44, 1'b0});
    @(negedge clk);
    check_eq("b_op_count", {16'd0, b_op_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
